// File: rtl/histogram_sequencer.sv
// One histogram pass: clear all bins, stream the image, and accumulate each pixel
// into its bin with a read-increment-write pipeline that forwards same-bin hazards.
module histogram_sequencer #(
   parameter int ADDR_W = 13,
   parameter int PIX_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_pixels,
   output logic              busy,
   output logic              done,
   output logic              saturated,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [PIX_W-1:0]  img_data,
   output logic [PIX_W-1:0]  bin_addr,
   output logic [PIX_W-1:0]  bin_raddr,
   output logic              bin_we,
   output logic [CNT_W-1:0]  bin_wdata,
   input  logic [CNT_W-1:0]  bin_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [PIX_W-1:0]  clr_q, clr_d;
   logic              drain_q, drain_d;
   logic              sat_q, sat_d;
   logic              vld_p1_q, vld_p1_d;
   logic              vld_p2_q;
   logic [PIX_W-1:0]  pix_p2_q;
   logic              fwd_vld_q;
   logic [PIX_W-1:0]  fwd_addr_q;
   logic [CNT_W-1:0]  fwd_data_q;
   logic [PIX_W-1:0]  raddr_q;
   logic [PIX_W-1:0]  baddr_q;
   logic [CNT_W-1:0]  wdata_q;
   logic              clearing;
   logic              fwd_hit;
   logic [CNT_W-1:0]  old_cnt;
   logic [CNT_W-1:0]  new_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic is_full(input logic [CNT_W-1:0] v);
      return v == {CNT_W{1'b1}};
   endfunction

   // The previous write lands in the same cycle as this bin's read, so its data is stale.
   assign fwd_hit  = fwd_vld_q && (fwd_addr_q == pix_p2_q);
   assign old_cnt  = fwd_hit ? fwd_data_q : bin_rdata;
   assign new_cnt  = sat_inc(old_cnt);
   assign clearing = (state_q == S_CLEAR);

   assign img_addr  = k_q;
   assign bin_raddr = vld_p1_q ? img_data : raddr_q;
   assign bin_we    = clearing | vld_p2_q;
   assign bin_addr  = clearing ? clr_q : (vld_p2_q ? pix_p2_q : baddr_q);
   assign bin_wdata = clearing ? '0 : (vld_p2_q ? new_cnt : wdata_q);
   assign saturated = sat_q;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      k_d      = k_q;
      clr_d    = clr_q;
      drain_d  = drain_q;
      sat_d    = sat_q;
      vld_p1_d = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = num_pixels;
               sat_d   = 1'b0;
               clr_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy  = 1'b1;
            clr_d = clr_q + 1'b1;
            if (clr_q == {PIX_W{1'b1}}) begin
               if (n_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SCAN;
                  k_d     = '0;
               end
            end
         end
         S_SCAN: begin
            busy     = 1'b1;
            vld_p1_d = 1'b1;
            if (k_q == n_q - 1'b1) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (vld_p2_q && is_full(old_cnt)) sat_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         k_q       <= '0;
         clr_q     <= '0;
         drain_q   <= 1'b0;
         sat_q     <= 1'b0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         fwd_vld_q <= 1'b0;
         raddr_q   <= '0;
         baddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         k_q       <= k_d;
         clr_q     <= clr_d;
         drain_q   <= drain_d;
         sat_q     <= sat_d;
         // stage 0 -> 1: image read issued
         vld_p1_q  <= vld_p1_d;
         // stage 1 -> 2: bin read issued
         vld_p2_q  <= vld_p1_q;
         // stage 2 -> forward entry
         fwd_vld_q <= vld_p2_q;
         raddr_q   <= bin_raddr;
         baddr_q   <= bin_addr;
         wdata_q   <= bin_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (vld_p1_q) pix_p2_q <= img_data;
      if (vld_p2_q) begin
         fwd_addr_q <= pix_p2_q;
         fwd_data_q <= new_cnt;
      end
   end

endmodule

// File: tb/tb_histogram_sequencer.sv
// Bench for histogram_sequencer: memory models, a cycle-timed pass model and
// literal expectations for each directed pass.
module tb_histogram_sequencer;

   localparam int ADDR_W = 13;
   localparam int PIX_W  = 8;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] num_pixels;
   logic              busy, done, saturated, bin_we;
   logic [ADDR_W-1:0] img_addr;
   logic [PIX_W-1:0]  img_data, bin_addr, bin_raddr;
   logic [CNT_W-1:0]  bin_wdata, bin_rdata;

   logic              start_b;
   logic [ADDR_W-1:0] num_b;
   logic              busy_b, done_b, sat_b, bin_we_b;
   logic [ADDR_W-1:0] img_addr_b;
   logic [PIX_W-1:0]  img_data_b, bin_addr_b, bin_raddr_b;
   logic [3:0]        bin_wdata_b, bin_rdata_b;

   logic [7:0]  img_mem [0:8191];
   logic [15:0] hist    [0:255];
   logic [7:0]  img_b   [0:8191];
   logic [3:0]  hist_b  [0:255];
   logic        preload;

   histogram_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(rst_n), .start(start), .num_pixels(num_pixels),
      .busy(busy), .done(done), .saturated(saturated),
      .img_addr(img_addr), .img_data(img_data),
      .bin_addr(bin_addr), .bin_raddr(bin_raddr), .bin_we(bin_we),
      .bin_wdata(bin_wdata), .bin_rdata(bin_rdata)
   );

   histogram_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(4)) dut_b (
      .clk(clk), .reset(rst_n), .start(start_b), .num_pixels(num_b),
      .busy(busy_b), .done(done_b), .saturated(sat_b),
      .img_addr(img_addr_b), .img_data(img_data_b),
      .bin_addr(bin_addr_b), .bin_raddr(bin_raddr_b), .bin_we(bin_we_b),
      .bin_wdata(bin_wdata_b), .bin_rdata(bin_rdata_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memories; a read of an address written in the same cycle returns old data.
   always @(posedge clk) begin
      img_data    <= img_mem[img_addr];
      bin_rdata   <= hist[bin_raddr];
      img_data_b  <= img_b[img_addr_b];
      bin_rdata_b <= hist_b[bin_raddr_b];
      if (preload) begin
         for (int i = 0; i < 256; i++) hist[i] <= 16'hABCD;
      end else if (bin_we) begin
         hist[bin_addr] <= bin_wdata;
      end
      if (bin_we_b) hist_b[bin_addr_b] <= bin_wdata_b;
   end

   bit st_smp;
   int n_smp;
   always @(posedge clk) begin
      st_smp <= start && rst_n;
      n_smp  <= int'(num_pixels);
   end

   // literal expectations, written by the stimulus before each pass
   int lit_done, lit_nb, lit_wn;
   int lit_bin [0:7];
   int lit_val [0:7];
   int lit_wseq[0:15];

   // model and scoreboard state, owned by the compare process
   int n_chk, n_fail, passes, b_passes;
   bit active, was_done, exp_sat, b_sat_chk;
   int cyc, n_cur, lb, img_hold, wcount, ia_e;
   int mh[0:255];
   int pix_cur[0:63];
   int ew_addr[0:63];
   int ew_data[0:63];
   int wseq[0:15];
   bit we_e;

   task automatic chk(input string nm, input longint act, input longint exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_bin_we", bin_we, 0);
         chk("rst_img_addr", img_addr, 0);
         chk("rst_bin_addr", bin_addr, 0);
         chk("rst_bin_raddr", bin_raddr, 0);
         chk("rst_bin_wdata", bin_wdata, 0);
         chk("rst_saturated", saturated, 0);
         active = 0; was_done = 0; img_hold = 0; exp_sat = 0;
      end else begin
         if (!active && st_smp && !was_done) begin
            active = 1; cyc = 0; n_cur = n_smp; wcount = 0; exp_sat = 0;
            lb = (n_cur == 0) ? 256 : 258 + n_cur;
            for (int b = 0; b < 256; b++) mh[b] = 0;
            for (int k = 0; k < n_cur; k++) begin
               pix_cur[k] = int'(img_mem[k]);
               if (mh[pix_cur[k]] == 65535) exp_sat = 1;
               else mh[pix_cur[k]] = mh[pix_cur[k]] + 1;
               ew_addr[k] = pix_cur[k];
               ew_data[k] = mh[pix_cur[k]];
            end
         end
         was_done = 0;
         if (active) begin
            cyc++;
            chk("busy", busy, cyc <= lb);
            chk("done", done, cyc == lb + 1);
            we_e = (cyc <= 256) || (n_cur > 0 && cyc >= 259 && cyc <= 258 + n_cur);
            chk("bin_we", bin_we, we_e);
            if (we_e && cyc <= 256) begin
               chk("clr_addr", bin_addr, cyc - 1);
               chk("clr_wdata", bin_wdata, 0);
            end
            if (we_e && cyc >= 259) begin
               chk("wr_addr", bin_addr, ew_addr[cyc-259]);
               chk("wr_data", bin_wdata, ew_data[cyc-259]);
            end
            if (n_cur > 0 && cyc >= 257 && cyc <= 256 + n_cur) ia_e = cyc - 257;
            else if (n_cur > 0 && cyc > 256 + n_cur) ia_e = n_cur - 1;
            else ia_e = img_hold;
            chk("img_addr", img_addr, ia_e);
            if (n_cur > 0 && cyc >= 258 && cyc <= 257 + n_cur)
               chk("bin_raddr", bin_raddr, pix_cur[cyc-258]);
            if (cyc > 256 && bin_we) begin
               if (wcount < 16) wseq[wcount] = int'(bin_wdata);
               wcount++;
            end
            if (done && lit_done > 0) chk("done_cycle", cyc, lit_done);
            if (cyc == lb + 1) begin
               chk("saturated", saturated, exp_sat);
               for (int b = 0; b < 256; b++) chk($sformatf("bin%0d", b), hist[b], mh[b]);
               for (int i = 0; i < lit_nb; i++)
                  chk($sformatf("lit_bin%0d", lit_bin[i]), hist[lit_bin[i]], lit_val[i]);
               if (lit_wn >= 0) begin
                  chk("scan_writes", wcount, lit_wn);
                  for (int i = 0; i < lit_wn && i < 16; i++)
                     chk($sformatf("wseq%0d", i), wseq[i], lit_wseq[i]);
               end
               if (n_cur > 0) img_hold = n_cur - 1;
               active = 0; was_done = 1; passes++;
            end
         end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_bin_we", bin_we, 0);
            chk("idle_img_addr", img_addr, img_hold);
            chk("idle_saturated", saturated, exp_sat);
         end
         if (done_b) begin
            if (b_passes == 0) begin
               chk("sat_bin42", hist_b[42], 15);
               chk("sat_bin41", hist_b[41], 0);
               chk("sat_flag", sat_b, 1);
            end
            b_passes++;
         end else if (b_passes == 1 && !b_sat_chk && busy_b) begin
            chk("sat_cleared", sat_b, 0);
            b_sat_chk = 1;
         end else if (b_passes == 1 && !b_sat_chk) begin
            chk("sat_sticky", sat_b, 1);
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic lit_reset(input int d);
      lit_done = d; lit_nb = 0; lit_wn = -1;
   endtask

   task automatic add_bin(input int b, input int v);
      lit_bin[lit_nb] = b; lit_val[lit_nb] = v; lit_nb++;
   endtask

   task automatic add_w(input int v);
      if (lit_wn < 0) lit_wn = 0;
      lit_wseq[lit_wn] = v; lit_wn++;
   endtask

   task automatic run_pass(input int n, input int pulse_c, input int rst_c);
      int p0;
      bit fin;
      p0 = passes; fin = 0;
      num_pixels = ADDR_W'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= n + 300 && !fin; c++) begin
         start = (c == pulse_c);
         if (c == rst_c) begin
            #3 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            fin = 1;
         end else begin
            @(posedge clk); #1;
            if (passes != p0) fin = 1;
         end
      end
      start = 1'b0;
      if (!fin) begin
         $display("FAIL run_pass: no completion within bound for n=%0d", n);
         $fatal(1, "pass did not complete");
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_pixels = '0; preload = 1'b0;
      start_b = 1'b0; num_b = '0;
      for (int i = 0; i < 8192; i++) begin
         img_mem[i] = 8'd0;
         img_b[i]   = 8'd42;
      end
      lit_reset(0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(3);

      // basic; start held in the DONE cycle must be ignored
      img_mem[0] = 8'd3; img_mem[1] = 8'd9; img_mem[2] = 8'd200; img_mem[3] = 8'd255;
      lit_reset(263);
      add_bin(3, 1); add_bin(9, 1); add_bin(200, 1); add_bin(255, 1); add_bin(0, 0);
      add_w(1); add_w(1); add_w(1); add_w(1);
      run_pass(4, 263, 0);
      idle(4);

      // back-to-back hits on one bin
      img_mem[0] = 8'd5; img_mem[1] = 8'd5; img_mem[2] = 8'd5; img_mem[3] = 8'd7; img_mem[4] = 8'd5;
      lit_reset(264);
      add_bin(5, 4); add_bin(7, 1);
      add_w(1); add_w(2); add_w(3); add_w(1); add_w(4);
      run_pass(5, 0, 0);
      idle(3);

      // empty image
      lit_reset(257);
      add_bin(5, 0); add_bin(7, 0);
      lit_wn = 0;
      run_pass(0, 0, 0);
      idle(3);

      // clear overwrites stale contents
      preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      img_mem[0] = 8'd0;
      lit_reset(260);
      add_bin(0, 1); add_bin(1, 0); add_bin(128, 0); add_bin(255, 0);
      add_w(1);
      run_pass(1, 0, 0);
      idle(3);

      // start pulsed during SCAN
      for (int k = 0; k < 10; k++) img_mem[k] = 8'((k % 3) * 50);
      lit_reset(269);
      add_bin(0, 4); add_bin(50, 3); add_bin(100, 3);
      add_w(1); add_w(1); add_w(1); add_w(2); add_w(2);
      add_w(2); add_w(3); add_w(3); add_w(3); add_w(4);
      run_pass(10, 262, 0);
      idle(3);

      // reset in cycle 260 abandons the pass
      lit_reset(0);
      run_pass(10, 0, 260);
      idle(6);

      // full pass after the abandoned one
      img_mem[0] = 8'd1; img_mem[1] = 8'd2; img_mem[2] = 8'd1;
      img_mem[3] = 8'd1; img_mem[4] = 8'd255; img_mem[5] = 8'd2;
      lit_reset(265);
      add_bin(1, 3); add_bin(2, 2); add_bin(255, 1);
      add_w(1); add_w(1); add_w(2); add_w(3); add_w(1); add_w(2);
      run_pass(6, 0, 0);
      idle(3);

      // longer run with repeated pixels
      for (int k = 0; k < 40; k++) img_mem[k] = 8'((k / 3) % 4);
      lit_reset(299);
      add_bin(0, 12); add_bin(1, 10); add_bin(2, 9); add_bin(3, 9);
      run_pass(40, 0, 0);
      idle(3);

      // saturation on the 4-bit instance, then a second start clears the flag
      num_b = ADDR_W'(20);
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int c = 0; c < 400 && b_passes < 1; c++) begin
         @(posedge clk); #1;
      end
      if (b_passes < 1) begin
         $display("FAIL sat_pass: no done within bound");
         $fatal(1, "saturation pass did not complete");
      end
      idle(4);
      num_b = '0;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int c = 0; c < 400 && b_passes < 2; c++) begin
         @(posedge clk); #1;
      end
      if (b_passes < 2) begin
         $display("FAIL sat_pass2: no done within bound");
         $fatal(1, "second saturation pass did not complete");
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
